buffer_tx: RTL and testbench



---
 rtl/buffer_tx.sv | 137 +++++++++++++
 tb/tb_buffer_tx.sv | 235 +++++++++++++++++++++++
 2 files changed

// File: rtl/buffer_tx.sv
// buffer_tx: serializes one WORD_W word into NUM_BYTES bytes, LSB first.
// Optional prefetch holding register: define BUFFER_TX_PREFETCH_EN.
module buffer_tx #(
  parameter int WORD_W = 32,
  parameter int BYTE_W = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              word_valid,
  output logic              word_ready,
  input  logic [WORD_W-1:0] data_in,
  output logic              byte_valid,
  input  logic              byte_ready,
  input  logic              full,
  output logic [BYTE_W-1:0] data_out,
  output logic              busy
);

  localparam int NUM_BYTES = WORD_W / BYTE_W;
  localparam int IDX_W = (NUM_BYTES > 1) ? $clog2(NUM_BYTES) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_BYTES - 1);

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    SEND = 2'b01
  } state_t;

  state_t            r_state;
  state_t            w_next;
  logic [WORD_W-1:0] r_shift;
  logic [IDX_W-1:0]  r_idx;
  logic              w_acc;
  logic              w_xfer;
  logic              w_last;
  logic              w_more;

`ifdef BUFFER_TX_PREFETCH_EN
  logic [WORD_W-1:0] r_hold;
  logic              r_hold_v;
`endif

  assign w_acc    = word_valid & word_ready;
  assign w_xfer   = (r_state == SEND) & byte_ready & ~full;
  assign w_last   = (r_idx == LAST_IDX);
  assign data_out = r_shift[BYTE_W-1:0];

`ifdef BUFFER_TX_PREFETCH_EN
  assign w_more = r_hold_v | w_acc;
`else
  assign w_more = 1'b0;
`endif

  // State register
  always_ff @(posedge clk) begin
    if (rst) r_state <= IDLE;
    else     r_state <= w_next;
  end

  // Next-state: stay in SEND after the last byte only if another word is ready
  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE: if (w_acc) w_next = SEND;
      SEND: if (w_xfer && w_last)
              w_next = w_more ? SEND : IDLE;
      default: w_next = IDLE;
    endcase
  end

  // Outputs decoded from state
  always_comb begin
    byte_valid = (r_state == SEND);
    busy       = (r_state == SEND);
`ifdef BUFFER_TX_PREFETCH_EN
    word_ready = ~rst & ~r_hold_v &
                 ((r_state == IDLE) | (r_state == SEND));
`else
    word_ready = ~rst & (r_state == IDLE);
`endif
  end

  // Datapath: shift register, byte index and optional holding register
  always_ff @(posedge clk) begin
    if (rst) begin
      r_shift  <= '0;
      r_idx    <= '0;
`ifdef BUFFER_TX_PREFETCH_EN
      r_hold   <= '0;
      r_hold_v <= 1'b0;
`endif
    end else begin
      case (r_state)
        IDLE: begin
          if (w_acc) begin
            r_shift <= data_in;
            r_idx   <= '0;
          end
        end
        SEND: begin
          if (w_xfer && !w_last) begin
            r_shift <= r_shift >> BYTE_W;
            r_idx   <= r_idx + 1'b1;
          end else if (w_xfer) begin
`ifdef BUFFER_TX_PREFETCH_EN
            if (r_hold_v) begin
              r_shift  <= r_hold;
              r_hold_v <= 1'b0;
            end else if (w_acc) begin
              r_shift <= data_in;
            end else begin
              r_shift <= r_shift >> BYTE_W;
            end
`else
            r_shift <= r_shift >> BYTE_W;
`endif
            r_idx <= '0;
          end
`ifdef BUFFER_TX_PREFETCH_EN
          // Park the word unless it goes straight into the shifter
          if (w_acc && !(w_xfer && w_last)) begin
            r_hold   <= data_in;
            r_hold_v <= 1'b1;
          end
`endif
        end
        default: begin
          r_shift  <= '0;
          r_idx    <= '0;
`ifdef BUFFER_TX_PREFETCH_EN
          r_hold_v <= 1'b0;
`endif
        end
      endcase
    end
  end

endmodule

// File: tb/tb_buffer_tx.sv
// tb_buffer_tx: scoreboard bench for buffer_tx.
// Directed sequences plus randomized ready/full traffic.
module tb_buffer_tx;

  localparam int WW = 32;
  localparam int BW = 8;
  localparam int NB = WW / BW;

  logic          clk = 1'b0;
  logic          rst;
  logic          word_valid;
  logic          word_ready;
  logic [WW-1:0] data_in;
  logic          byte_valid;
  logic          byte_ready;
  logic          full;
  logic [BW-1:0] data_out;
  logic          busy;

  int total = 0;
  int bad   = 0;
  logic [BW-1:0] exp_q[$];

  buffer_tx dut (
    .clk        (clk),
    .rst        (rst),
    .word_valid (word_valid),
    .word_ready (word_ready),
    .data_in    (data_in),
    .byte_valid (byte_valid),
    .byte_ready (byte_ready),
    .full       (full),
    .data_out   (data_out),
    .busy       (busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask

  // Scoreboard: handshakes seen at negedge are the ones taken next posedge
  always @(negedge clk) begin
    if (rst) begin
      exp_q.delete();
    end else begin
      if (byte_valid && byte_ready && !full) begin
        if (exp_q.size() == 0) begin
          total++;
          bad++;
          $display("FAIL sb_extra: got %0h want none", data_out);
        end else begin
          chk("sb_byte", 32'(data_out), 32'(exp_q.pop_front()));
        end
      end
      if (word_valid && word_ready)
        for (int i = 0; i < NB; i++)
          exp_q.push_back(BW'(data_in >> (BW * i)));
    end
  end

  task automatic send_word(input logic [WW-1:0] w);
    bit done;
    done = 1'b0;
    word_valid = 1'b1;
    data_in = w;
    for (int k = 0; k < 300 && !done; k++) begin
      @(negedge clk);
      if (word_ready) done = 1'b1;
    end
    @(posedge clk);
    #1;
    word_valid = 1'b0;
    data_in = $urandom;
    if (!done) chk("accept_timeout", 32'(0), 32'(1));
  endtask

  task automatic drain();
    bit done;
    done = 1'b0;
    for (int k = 0; k < 600 && !done; k++) begin
      @(negedge clk);
      if (exp_q.size() == 0 && !busy) done = 1'b1;
    end
    chk("drain", 32'(done), 32'(1));
    @(posedge clk);
    #1;
  endtask

  logic [BW-1:0] seq2[7];
  bit rnd_done;

  initial begin
    rst = 1'b1;
    word_valid = 1'b0;
    data_in = '0;
    byte_ready = 1'b0;
    full = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    @(negedge clk);
    chk("rst_valid", 32'(byte_valid), 32'(0));
    chk("rst_busy", 32'(busy), 32'(0));
    chk("rst_data", 32'(data_out), 32'(0));
    chk("rst_wready", 32'(word_ready), 32'(0));
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    chk("idle_wready", 32'(word_ready), 32'(1));
    @(posedge clk);
    #1;

    // 1: plain word, consecutive bytes one cycle after accept
    byte_ready = 1'b1;
    send_word(32'hA1B2C3D4);
    for (int i = 0; i < NB; i++) begin
      @(negedge clk);
      chk("t1_valid", 32'(byte_valid), 32'(1));
      chk("t1_byte", 32'(data_out), 32'((32'hA1B2C3D4 >> (8 * i)) & 32'hFF));
    end
    @(negedge clk);
    chk("t1_vdone", 32'(byte_valid), 32'(0));
    chk("t1_wready", 32'(word_ready), 32'(1));
    @(posedge clk);
    #1;

    // 2: full stall on the third byte
    seq2 = '{8'hD4, 8'hC3, 8'hB2, 8'hB2, 8'hB2, 8'hB2, 8'hA1};
    send_word(32'hA1B2C3D4);
    for (int c = 0; c < 7; c++) begin
      if (c == 2) full = 1'b1;
      if (c == 5) full = 1'b0;
      @(negedge clk);
      chk("t2_valid", 32'(byte_valid), 32'(1));
      chk("t2_byte", 32'(data_out), 32'(seq2[c]));
      @(posedge clk);
      #1;
    end
    @(negedge clk);
    chk("t2_vdone", 32'(byte_valid), 32'(0));
    chk("t2_count", 32'(exp_q.size()), 32'(0));
    @(posedge clk);
    #1;

    // 3: second word offered while serializing
    send_word(32'hA1B2C3D4);
    word_valid = 1'b1;
    data_in = 32'h11223344;
`ifndef BUFFER_TX_PREFETCH_EN
    for (int i = 0; i < NB; i++) begin
      @(negedge clk);
      chk("t3_wready_lo", 32'(word_ready), 32'(0));
    end
`endif
    send_word(32'h11223344);
    drain();

    // 4: reset after two bytes discards the rest
    send_word(32'hDEADBEEF);
    repeat (2) begin
      @(posedge clk);
      #1;
    end
    rst = 1'b1;
    byte_ready = 1'b0;
    @(negedge clk);
    chk("t4_wready_rst", 32'(word_ready), 32'(0));
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    chk("t4_valid", 32'(byte_valid), 32'(0));
    chk("t4_data", 32'(data_out), 32'(0));
    chk("t4_busy", 32'(busy), 32'(0));
    @(posedge clk);
    #1;
    byte_ready = 1'b1;
    send_word(32'h00000055);
    drain();

`ifdef BUFFER_TX_PREFETCH_EN
    // 5: back-to-back words with no bubble
    send_word(32'h03020100);
    word_valid = 1'b1;
    data_in = 32'h07060504;
    for (int i = 0; i < 2 * NB; i++) begin
      @(negedge clk);
      chk("t5_valid", 32'(byte_valid), 32'(1));
      chk("t5_byte", 32'(data_out), 32'(i));
      @(posedge clk);
      #1;
      if (i == 0) word_valid = 1'b0;
    end
    drain();
`endif

    // 6: random words with random ready/full
    rnd_done = 1'b0;
    fork
      begin
        for (int n = 0; n < 100; n++) begin
          repeat ($urandom_range(0, 3)) begin
            @(posedge clk);
            #1;
          end
          send_word($urandom);
        end
        rnd_done = 1'b1;
      end
      begin
        while (!rnd_done) begin
          byte_ready = $urandom_range(0, 1) == 1;
          full = $urandom_range(0, 3) == 0;
          @(posedge clk);
          #1;
        end
      end
    join
    byte_ready = 1'b1;
    full = 1'b0;
    drain();
    chk("final_empty", 32'(exp_q.size()), 32'(0));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
